// File: rtl/dma_transfer_ctrl.sv
// Top-level sequencer for one DMA channel: validates a copy request, launches both masters
// together, and tracks completion, write-response errors, timeout and abort.
module dma_transfer_ctrl #(
  parameter int unsigned C_ADDR_WIDTH     = 32,
  parameter int unsigned C_LEN_WIDTH      = 32,
  parameter int unsigned C_TIMEOUT_CYCLES = 1048576,
  parameter int unsigned C_FLUSH_CYCLES   = 4
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESETN,
  input  logic                    i_cfg_start,
  input  logic [C_ADDR_WIDTH-1:0] i_cfg_src_addr,
  input  logic [C_ADDR_WIDTH-1:0] i_cfg_dst_addr,
  input  logic [C_LEN_WIDTH-1:0]  i_cfg_len,
  input  logic                    i_abort,
  input  logic                    i_irq_clr,
  input  logic                    i_read_done,
  input  logic                    i_write_done,
  input  logic                    i_wr_resp_err,
  output logic                    o_rd_start,
  output logic [C_ADDR_WIDTH-1:0] o_rd_src_addr,
  output logic                    o_wr_start,
  output logic [C_ADDR_WIDTH-1:0] o_wr_dst_addr,
  output logic [C_LEN_WIDTH-1:0]  o_total_len,
  output logic                    o_core_rst_n,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_irq,
  output logic [2:0]              o_status
);

  localparam int unsigned FlushW = (C_FLUSH_CYCLES > 1) ? $clog2(C_FLUSH_CYCLES) : 1;
  localparam logic [FlushW-1:0] FlushLast = FlushW'(C_FLUSH_CYCLES - 1);
  localparam logic [C_LEN_WIDTH-1:0] TimeoutLast = C_LEN_WIDTH'(C_TIMEOUT_CYCLES - 1);
  localparam logic TimeoutEn = (C_TIMEOUT_CYCLES != 0);

  localparam logic [2:0] StatOk        = 3'd0;
  localparam logic [2:0] StatLenZero   = 3'd1;
  localparam logic [2:0] StatUnaligned = 3'd2;
  localparam logic [2:0] StatSlvErr    = 3'd3;
  localparam logic [2:0] StatTimeout   = 3'd4;
  localparam logic [2:0] StatAbort     = 3'd5;

  typedef enum logic [2:0] {StIdle, StCheck, StLaunch, StRun, StFlush, StErr, StDone} state_e;

  state_e                  state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] src_q, dst_q;
  logic [C_LEN_WIDTH-1:0]  len_q;
  logic [2:0]              status_q, status_d;
  logic                    irq_q, core_rst_n_q;
  logic                    rd_seen_q, rd_seen_d, wr_seen_q, wr_seen_d;
  logic [C_LEN_WIDTH-1:0]  run_cnt_q, run_cnt_d;
  logic [FlushW-1:0]       flush_cnt_q, flush_cnt_d;
  logic                    latch;
  logic                    rd_now, wr_now;

  assign rd_now = rd_seen_q | i_read_done;
  assign wr_now = wr_seen_q | i_write_done;

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    rd_seen_d   = rd_seen_q;
    wr_seen_d   = wr_seen_q;
    run_cnt_d   = '0;
    flush_cnt_d = '0;
    latch       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_cfg_start) begin
          latch     = 1'b1;
          status_d  = StatOk;
          rd_seen_d = 1'b0;
          wr_seen_d = 1'b0;
          state_d   = StCheck;
        end
      end
      StCheck: begin
        // Check-stage errors skip the flush: nothing downstream was started.
        if (len_q == '0) begin
          status_d = StatLenZero;
          state_d  = StErr;
        end else if (|{src_q[1:0], dst_q[1:0], len_q[1:0]}) begin
          status_d = StatUnaligned;
          state_d  = StErr;
        end else begin
          state_d = StLaunch;
        end
      end
      StLaunch: state_d = StRun;
      StRun: begin
        rd_seen_d = rd_now;
        wr_seen_d = wr_now;
        run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 1'b1;
        if (i_wr_resp_err) begin
          status_d = StatSlvErr;
          state_d  = StFlush;
        end else if (i_abort) begin
          status_d = StatAbort;
          state_d  = StFlush;
        end else if (TimeoutEn && (run_cnt_q == TimeoutLast)) begin
          status_d = StatTimeout;
          state_d  = StFlush;
        end else if (rd_now && wr_now) begin
          status_d = StatOk;
          state_d  = StDone;
        end
      end
      StFlush: begin
        if (flush_cnt_q == FlushLast) state_d = StErr;
        else flush_cnt_d = flush_cnt_q + 1'b1;
      end
      StErr, StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      status_q     <= StatOk;
      irq_q        <= 1'b0;
      core_rst_n_q <= 1'b1;
      rd_seen_q    <= 1'b0;
      wr_seen_q    <= 1'b0;
      run_cnt_q    <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      rd_seen_q    <= rd_seen_d;
      wr_seen_q    <= wr_seen_d;
      run_cnt_q    <= run_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      core_rst_n_q <= (state_d != StFlush);
      if (latch) begin
        src_q <= i_cfg_src_addr;
        dst_q <= i_cfg_dst_addr;
        len_q <= i_cfg_len;
      end
      // Set wins over a simultaneous clear.
      if (state_d == StErr || state_d == StDone) irq_q <= 1'b1;
      else if (i_irq_clr) irq_q <= 1'b0;
    end
  end

  assign o_rd_start    = (state_q == StLaunch);
  assign o_wr_start    = (state_q == StLaunch);
  assign o_rd_src_addr = src_q;
  assign o_wr_dst_addr = dst_q;
  assign o_total_len   = len_q;
  assign o_core_rst_n  = core_rst_n_q;
  assign o_busy        = (state_q == StCheck) || (state_q == StLaunch) ||
                         (state_q == StRun) || (state_q == StFlush);
  assign o_done        = (state_q == StErr) || (state_q == StDone);
  assign o_irq         = irq_q;
  assign o_status      = status_q;

endmodule

// File: tb/tb_dma_transfer_ctrl.sv
// Bench for dma_transfer_ctrl: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a timeline model of each transfer.
module tb_dma_transfer_ctrl;

  localparam int unsigned TO = 100;
  localparam int unsigned FL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cfg_start = 0, abort = 0, irq_clr = 0, rd_done = 0, wr_done = 0, resp_err = 0;
  logic [31:0] src = 0, dst = 0, len = 0;
  logic        rd_start, wr_start, core_rst_n, busy, done, irq;
  logic [31:0] rd_src, wr_dst, total_len;
  logic [2:0]  status;

  logic        b_start = 0, b_rd_done = 0, b_wr_done = 0;
  logic        b_rd_start, b_wr_start, b_core_rst_n, b_busy, b_done, b_irq;
  logic [31:0] b_rd_src, b_wr_dst, b_total_len;
  logic [2:0]  b_status;

  dma_transfer_ctrl #(
    .C_ADDR_WIDTH(32), .C_LEN_WIDTH(32), .C_TIMEOUT_CYCLES(TO), .C_FLUSH_CYCLES(FL)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .i_cfg_start(cfg_start),
    .i_cfg_src_addr(src), .i_cfg_dst_addr(dst), .i_cfg_len(len), .i_abort(abort),
    .i_irq_clr(irq_clr), .i_read_done(rd_done), .i_write_done(wr_done),
    .i_wr_resp_err(resp_err), .o_rd_start(rd_start), .o_rd_src_addr(rd_src),
    .o_wr_start(wr_start), .o_wr_dst_addr(wr_dst), .o_total_len(total_len),
    .o_core_rst_n(core_rst_n), .o_busy(busy), .o_done(done), .o_irq(irq), .o_status(status)
  );

  // Timeout disabled instance.
  dma_transfer_ctrl #(
    .C_ADDR_WIDTH(32), .C_LEN_WIDTH(32), .C_TIMEOUT_CYCLES(0), .C_FLUSH_CYCLES(FL)
  ) dut_nto (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .i_cfg_start(b_start),
    .i_cfg_src_addr(32'h0000_4000), .i_cfg_dst_addr(32'h0000_5000), .i_cfg_len(32'h0000_0100),
    .i_abort(1'b0), .i_irq_clr(1'b0), .i_read_done(b_rd_done), .i_write_done(b_wr_done),
    .i_wr_resp_err(1'b0), .o_rd_start(b_rd_start), .o_rd_src_addr(b_rd_src),
    .o_wr_start(b_wr_start), .o_wr_dst_addr(b_wr_dst), .o_total_len(b_total_len),
    .o_core_rst_n(b_core_rst_n), .o_busy(b_busy), .o_done(b_done), .o_irq(b_irq),
    .o_status(b_status)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_rst_low = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer timeline model. Age counts cycles since the accepted start (age 1 = check cycle,
  // 2 = launch, 3.. = run). end_age is the cycle of the done pulse, flush_age the first
  // cycle the core reset is held.
  bit          m_active = 0, m_rd = 0, m_wr = 0, m_irq = 0;
  int          m_age = 0, m_end = -1, m_flush = -1, m_code = 0;
  logic [31:0] m_src = 0, m_dst = 0, m_len = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_rd = 0; m_wr = 0; m_irq = 0;
      m_age = 0; m_end = -1; m_flush = -1; m_code = 0;
      m_src = 0; m_dst = 0; m_len = 0;
    end else begin
      if (m_active) begin
        if (m_age == m_end) begin
          m_active = 0;
        end else begin
          if (m_age >= 3 && m_flush < 0 && m_end < 0) begin
            m_rd = m_rd | rd_done;
            m_wr = m_wr | wr_done;
            if (resp_err) begin m_code = 3; m_flush = m_age + 1; end
            else if (abort) begin m_code = 5; m_flush = m_age + 1; end
            else if (m_age - 3 == int'(TO) - 1) begin m_code = 4; m_flush = m_age + 1; end
            else if (m_rd && m_wr) m_end = m_age + 1;
            if (m_flush >= 0) m_end = m_flush + int'(FL);
          end
          m_age++;
        end
      end else if (cfg_start) begin
        m_active = 1; m_age = 1; m_end = -1; m_flush = -1; m_code = 0; m_rd = 0; m_wr = 0;
        m_src = src; m_dst = dst; m_len = len;
        if (len == 0) begin m_code = 1; m_end = 2; end
        else if (src[1:0] != 0 || dst[1:0] != 0 || len[1:0] != 0) begin m_code = 2; m_end = 2; end
      end
      if (m_active && m_age == m_end) m_irq = 1;
      else if (irq_clr) m_irq = 0;
    end
  end

  always @(negedge clk) begin
    bit e_busy, e_done, e_launch, e_rstn;
    if (rst_n) begin
      e_busy   = m_active && (m_end < 0 || m_age < m_end);
      e_done   = m_active && (m_age == m_end);
      e_launch = m_active && (m_age == 2) && (m_end != 2);
      e_rstn   = !(m_active && m_flush >= 0 && m_age >= m_flush && m_age < m_end);
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("rd_start", 64'(rd_start), 64'(e_launch));
      chk("wr_start", 64'(wr_start), 64'(e_launch));
      chk("core_rst_n", 64'(core_rst_n), 64'(e_rstn));
      chk("irq", 64'(irq), 64'(m_irq));
      chk("rd_src_addr", 64'(rd_src), 64'(m_src));
      chk("wr_dst_addr", 64'(wr_dst), 64'(m_dst));
      chk("total_len", 64'(total_len), 64'(m_len));
      if (!e_busy) chk("status", 64'(status), 64'(m_code));
      if (!core_rst_n) n_rst_low++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    cfg_start = 0; abort = 0; irq_clr = 0; rd_done = 0; wr_done = 0; resp_err = 0;
    b_start = 0; b_rd_done = 0; b_wr_done = 0;
  endtask

  task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    cfg_start = 1; src = s; dst = d; len = l;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin tick(); c++; end
    chk("done_in_budget", 64'(done), 64'(1));
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  function automatic logic [31:0] rand_len();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'd0;
    if (k == 1) return 32'($urandom_range(1, 4095));
    return 32'($urandom_range(1, 1024) * 4);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, cnt, b_low, b_dn;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_core_rst_n", 64'(core_rst_n), 64'(1));
    chk("reset_status", 64'(status), 64'(0));
    chk("reset_irq", 64'(irq), 64'(0));
    chk("reset_src", 64'(rd_src), 64'(0));
    rst_n = 1;
    tick();

    // Nominal transfer: launch two cycles after start, done one after write done.
    start(32'h1000, 32'h8000, 32'h400);
    tick();
    chk("t1_check_rd_start", 64'(rd_start), 64'(0));
    chk("t1_check_src", 64'(rd_src), 64'h1000);
    tick();
    chk("t1_rd_start", 64'(rd_start), 64'(1));
    chk("t1_wr_start", 64'(wr_start), 64'(1));
    chk("t1_len", 64'(total_len), 64'h400);
    repeat (48) tick();
    rd_done = 1;
    tick();
    repeat (29) tick();
    wr_done = 1;
    tick();
    chk("t1_done", 64'(done), 64'(1));
    chk("t1_status", 64'(status), 64'(0));
    chk("t1_irq", 64'(irq), 64'(1));
    tick();
    chk("t1_irq_hold", 64'(irq), 64'(1));
    irq_clr = 1;
    tick();
    chk("t1_irq_clr", 64'(irq), 64'(0));

    // Check-stage errors.
    base = n_rst_low;
    start(32'h2000, 32'h3000, 32'h0);
    tick();
    chk("t2_no_done_c1", 64'(done), 64'(0));
    tick();
    chk("t2_done_c2", 64'(done), 64'(1));
    chk("t2_no_launch", 64'(rd_start), 64'(0));
    tick();
    chk("t2_status_lenzero", 64'(status), 64'(1));
    start(32'h1002, 32'h4000, 32'h8);
    tick();
    tick();
    chk("t2_done_unaligned", 64'(done), 64'(1));
    tick();
    chk("t2_status_unaligned", 64'(status), 64'(2));
    chk("t2_no_flush", 64'(n_rst_low - base), 64'(0));

    // SLVERR beats abort in the same cycle; flush lasts FL cycles.
    start(32'h100, 32'h200, 32'h40);
    repeat (5) tick();
    resp_err = 1; abort = 1;
    tick();
    base = n_rst_low;
    wait_done(20);
    chk("t3_status", 64'(status), 64'(3));
    chk("t3_flush_len", 64'(n_rst_low - base), 64'(FL));
    chk("t3_irq", 64'(irq), 64'(1));
    tick();

    // Timeout: flush begins TO cycles after run entry.
    start(32'h500, 32'h600, 32'h80);
    repeat (3) tick();
    cnt = 0;
    while (core_rst_n && cnt < 200) begin tick(); cnt++; end
    chk("t4_timeout_cycles", 64'(cnt), 64'(TO));
    wait_done(20);
    chk("t4_status", 64'(status), 64'(4));
    tick();

    // Both dones together, and a stray start during run.
    start(32'h700, 32'h900, 32'h10);
    repeat (7) tick();
    rd_done = 1; wr_done = 1;
    tick();
    chk("t5_done_both", 64'(done), 64'(1));
    tick();
    start(32'hA00, 32'hB00, 32'h20);
    repeat (4) tick();
    start(32'hDEAD_0000, 32'hBEEF_0000, 32'h44);
    tick();
    chk("t5_src_kept", 64'(rd_src), 64'hA00);
    chk("t5_dst_kept", 64'(wr_dst), 64'hB00);
    rd_done = 1; wr_done = 1;
    tick();
    chk("t5_done_after_stray", 64'(done), 64'(1));
    tick();

    // Asynchronous reset mid-run.
    start(32'hC00, 32'hD00, 32'h30);
    repeat (5) tick();
    #1 rst_n = 0;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_core", 64'(core_rst_n), 64'(1));
    chk("t6_rst_src", 64'(rd_src), 64'(0));
    chk("t6_rst_len", 64'(total_len), 64'(0));
    chk("t6_rst_irq", 64'(irq), 64'(0));
    chk("t6_rst_status", 64'(status), 64'(0));
    tick();
    rst_n = 1;
    tick();
    start(32'hE00, 32'hF00, 32'h40);
    repeat (3) tick();
    rd_done = 1;
    tick();
    wr_done = 1;
    tick();
    chk("t6_clean_done", 64'(done), 64'(1));
    chk("t6_clean_status", 64'(status), 64'(0));
    tick();

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) start(rand_addr(), rand_addr(), rand_len());
      rd_done  = ($urandom_range(0, 19) == 0);
      wr_done  = ($urandom_range(0, 19) == 0);
      resp_err = ($urandom_range(0, 149) == 0);
      abort    = ($urandom_range(0, 149) == 0);
      irq_clr  = ($urandom_range(0, 9) == 0);
      tick();
    end

    // Timeout disabled: long run never times out.
    b_start = 1;
    tick();
    b_low = 0;
    b_dn = 0;
    for (int i = 0; i < 10002; i++) begin
      tick();
      if (!b_core_rst_n) b_low++;
      if (b_done) b_dn++;
    end
    chk("t7_still_busy", 64'(b_busy), 64'(1));
    chk("t7_no_flush", 64'(b_low), 64'(0));
    chk("t7_no_done", 64'(b_dn), 64'(0));
    b_rd_done = 1; b_wr_done = 1;
    tick();
    chk("t7_done", 64'(b_done), 64'(1));
    chk("t7_status", 64'(b_status), 64'(0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_transfer_ctrl.md
Name: dma_transfer_ctrl

Overview:
- Top-level sequencer for one DMA channel. Validates a software-programmed copy request (src, dst, len) and launches the read master and the write master in the same cycle.
- Tracks both done flags and watches for write-response errors, timeout and abort.
- On an error it holds the datapath (masters + FIFO) in reset, then reports status and a level interrupt.
- Sits between the AXI-Lite register block and the read-master / FIFO / write-master datapath.

Parameters:
- C_ADDR_WIDTH, 32, width of source and destination addresses
- C_LEN_WIDTH, 32, width of the byte-length field
- C_TIMEOUT_CYCLES, 1048576, cycles allowed in RUN before timeout; 0 disables the timeout
- C_FLUSH_CYCLES, 4, cycles o_core_rst_n is held low on error or abort (minimum 1)

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  reset, asynchronous, active-low
- i_cfg_start  in  1  one-cycle start pulse from the register block
- i_cfg_src_addr  in  C_ADDR_WIDTH  source byte address
- i_cfg_dst_addr  in  C_ADDR_WIDTH  destination byte address
- i_cfg_len  in  C_LEN_WIDTH  total bytes to copy
- i_abort  in  1  software abort pulse
- i_irq_clr  in  1  clears o_irq (write-1 pulse)
- i_read_done  in  1  read master finished (pulse or level)
- i_write_done  in  1  write master finished (pulse or level)
- i_wr_resp_err  in  1  pulse when BVALID&&BREADY&&BRESP!=OKAY
- o_rd_start  out  1  one-cycle launch pulse to the read master
- o_rd_src_addr  out  C_ADDR_WIDTH  latched source address
- o_wr_start  out  1  one-cycle launch pulse to the write master
- o_wr_dst_addr  out  C_ADDR_WIDTH  latched destination address
- o_total_len  out  C_LEN_WIDTH  latched length, shared by both masters
- o_core_rst_n  out  1  active-low synchronous reset to the masters and FIFO
- o_busy  out  1  high from CHECK through FLUSH
- o_done  out  1  one-cycle pulse at the end of every transfer
- o_irq  out  1  level interrupt; set on transfer end, cleared by i_irq_clr
- o_status  out  3  0=OK, 1=LEN_ZERO, 2=UNALIGNED, 3=SLVERR, 4=TIMEOUT, 5=ABORT

Behaviour:
- Reset (ARESETN low, asynchronous):
  - state=IDLE; all pulses 0; o_busy=0; o_irq=0; o_status=0.
  - Latched address and length registers = 0.
  - o_core_rst_n=1, and it is registered.
- States:
  - IDLE: on i_cfg_start, latch src/dst/len, clear the status and sticky flags, go to CHECK. Aborts are ignored in IDLE.
  - CHECK (1 cycle):
    - len==0 -> ERR with LEN_ZERO.
    - Any of src[1:0], dst[1:0], len[1:0] nonzero -> ERR with UNALIGNED.
    - LEN_ZERO wins over UNALIGNED.
    - Otherwise go to LAUNCH.
  - LAUNCH (1 cycle): o_rd_start=o_wr_start=1 in the same cycle, go to RUN. The latched outputs are stable from CHECK until the next start.
  - RUN:
    - Set sticky rd_seen / wr_seen flags on i_read_done / i_write_done.
    - Count cycles in RUN.
    - Go to DONE when both flags are set (including a flag set this cycle).
  - RUN exit priority within one cycle: i_wr_resp_err (SLVERR) > i_abort (ABORT) > timeout (TIMEOUT) > completion.
  - Timeout fires on the cycle the counter reaches C_TIMEOUT_CYCLES-1.
  - Every error or abort in RUN goes to FLUSH.
  - FLUSH: o_core_rst_n=0 for exactly C_FLUSH_CYCLES cycles, then ERR.
  - ERR (1 cycle): o_done=1, o_irq set, status holds the code, go to IDLE.
  - DONE (1 cycle): o_done=1, o_irq set, status=OK, go to IDLE.
- i_cfg_start while not in IDLE is ignored and does not change the latched registers.
- i_irq_clr in the same cycle as an irq-set event: set wins.
- CHECK-stage errors skip FLUSH, because the masters were never started.
- The timeout counter is C_LEN_WIDTH wide, resets on entry to RUN and saturates.
- i_read_done / i_write_done are ignored outside RUN.
- o_status is sticky until the next accepted start.

Test Plan:
- Start src=0x1000, dst=0x8000, len=0x400; read done at +50 cycles, write done at +80 -> rd/wr start pulses in the same cycle 2 cycles after start; o_done 1 cycle after write done; status=0; o_irq=1 until i_irq_clr.
- Start with len=0 -> no launch pulses; o_done on cycle 2; status=1. Then src=0x1002, len=8 -> status=2; o_core_rst_n never low.
- In RUN, i_wr_resp_err and i_abort asserted in the same cycle -> status=3; o_core_rst_n low for exactly 4 cycles; then o_done and o_irq.
- C_TIMEOUT_CYCLES=100, no done inputs -> FLUSH entered 100 cycles after RUN entry; status=4. Repeat with C_TIMEOUT_CYCLES=0 and 10000 idle cycles -> no timeout.
- Both dones in the same cycle -> DONE next cycle. A second i_cfg_start during RUN -> ignored; latched addresses unchanged.
- Assert ARESETN low mid-RUN, asynchronously off the clock edge -> outputs reach reset values immediately. A later start runs a clean transfer with status=0.
